// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use/RAW stalls,
// taken-branch flushes, MUL/DIV occupancy of E and a saturating stall-cycle counter.
module hazard_ctrl_unit #(
  parameter int REG_AW     = 5,
  parameter int MULDIV_LAT = 4,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              RegWriteE,
  input  logic [1:0]        ResultSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              MulDivStartE,
  input  logic              CntClr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              MulDivBusy,
  output logic              MulDivDone,
  output logic [CNT_W-1:0]  StallCnt
);

  localparam bit MULTI = (MULDIV_LAT > 1);
  localparam int CW    = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
  localparam logic [CW-1:0] LOAD = CW'((MULDIV_LAT > 1) ? MULDIV_LAT - 2 : 0);

  typedef enum logic {IDLE, BUSY} md_state_e;

  md_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [1:0]       fwd_a, fwd_b;
  logic             lw_stall, raw_stall, md_stall, md_busy, md_done, stall_fd;

  function automatic logic hit(input logic we, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

  // M stage holds the younger result, so it wins over W
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      if (hit(RegWriteM, RdM, Rs1E))      fwd_a = 2'b10;
      else if (hit(RegWriteW, RdW, Rs1E)) fwd_a = 2'b01;
      if (hit(RegWriteM, RdM, Rs2E))      fwd_b = 2'b10;
      else if (hit(RegWriteW, RdW, Rs2E)) fwd_b = 2'b01;
    end
  end

  assign lw_stall  = RegWriteE && (ResultSrcE == 2'b01) &&
                     (hit(1'b1, RdE, Rs1D) || hit(1'b1, RdE, Rs2D));
  assign raw_stall = (FWD_EN == 0) &&
                     (hit(RegWriteE, RdE, Rs1D) || hit(RegWriteE, RdE, Rs2D) ||
                      hit(RegWriteM, RdM, Rs1D) || hit(RegWriteM, RdM, Rs2D) ||
                      hit(RegWriteW, RdW, Rs1D) || hit(RegWriteW, RdW, Rs2D));

  // done_q is precomputed so the pulse lands on the last occupancy cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (MULTI && MulDivStartE) begin
          state_q <= BUSY;
          cnt_q   <= LOAD;
          done_q  <= (LOAD == '0);
        end
        BUSY: if (cnt_q != '0) begin
          cnt_q  <= cnt_q - CW'(1);
          done_q <= (cnt_q == CW'(1));
        end else begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md_busy  = (state_q == BUSY);
  assign md_done  = MULTI ? done_q : MulDivStartE;
  assign md_stall = MULTI && ((!md_busy && MulDivStartE) || (md_busy && !done_q));
  assign stall_fd = lw_stall | raw_stall | md_stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (CntClr)                                stall_cnt_d = '0;
    else if (stall_fd && (stall_cnt_q != '1))  stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  // combinational outputs are forced low while reset is held
  assign ForwardAE  = rst ? fwd_a : 2'b00;
  assign ForwardBE  = rst ? fwd_b : 2'b00;
  assign StallF     = rst & stall_fd;
  assign StallD     = rst & stall_fd;
  assign StallE     = rst & md_stall;
  assign FlushD     = rst & PCSrcE;
  assign FlushE     = rst & (PCSrcE | ((lw_stall | raw_stall) & !md_stall));
  assign MulDivBusy = rst & md_busy;
  assign MulDivDone = rst & md_done;
  assign StallCnt   = stall_cnt_q;

endmodule
